// File: rtl/hex_scan_driver.sv
// Eight-digit hex scanner for a common-anode 7-segment display. A value is latched
// on a load strobe and promoted to the display only at a frame boundary.
module hex_scan_driver #(
  parameter int DIV_CYC = 50000,
  parameter int GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        upd_pending,
  output logic        frame_start
);

  localparam int MAX_CYC = (DIV_CYC > GAP_CYC) ? DIV_CYC : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic HAS_GAP = (GAP_CYC > 0);

  typedef enum logic [0:0] {
    ST_DRIVE = 1'b0,
    ST_GAP   = 1'b1
  } state_e;

  // Active-low hex glyphs, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero.
  function automatic logic lz_blank(input logic [31:0] word, input logic [2:0] k,
                                    input logic en);
    logic blank;
    if (en && (k != 3'd0) && ((word >> {k, 2'b00}) == 32'd0)) begin
      blank = 1'b1;
    end else begin
      blank = 1'b0;
    end
    return blank;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             started_q, started_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      pend_q, pend_d;
  logic             upd_pending_q, upd_pending_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       an_n_q, an_n_d;
  logic [6:0]       seg_n_q, seg_n_d;
  logic             enter_drive_s;
  logic             boundary_s;
  logic [3:0]       nib_s;

  // Scan sequencer: dwell counting and digit advance; started_q forces the first frame.
  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    cnt_d         = cnt_q + CNT_W'(1);
    started_d     = 1'b1;
    enter_drive_s = 1'b0;
    if (!started_q) begin
      state_d       = ST_DRIVE;
      digit_d       = 3'd0;
      cnt_d         = {CNT_W{1'b0}};
      enter_drive_s = 1'b1;
    end else begin
      case (state_q)
        ST_DRIVE: begin
          if (cnt_q == DIV_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            if (HAS_GAP) begin
              state_d = ST_GAP;
            end else begin
              digit_d       = digit_q + 3'd1;
              enter_drive_s = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d       = ST_DRIVE;
            digit_d       = digit_q + 3'd1;
            cnt_d         = {CNT_W{1'b0}};
            enter_drive_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d       = ST_DRIVE;
          digit_d       = 3'd0;
          cnt_d         = {CNT_W{1'b0}};
          enter_drive_s = 1'b1;
        end
      endcase
    end
    boundary_s = enter_drive_s & (digit_d == 3'd0);
  end

  // Pending/display registers; a load on the boundary edge bypasses straight to disp.
  always_comb begin
    disp_d        = disp_q;
    pend_d        = pend_q;
    upd_pending_d = upd_pending_q;
    if (boundary_s) begin
      if (load) begin
        disp_d        = value;
        pend_d        = value;
        upd_pending_d = 1'b0;
      end else if (upd_pending_q) begin
        disp_d        = pend_q;
        upd_pending_d = 1'b0;
      end else begin
        disp_d        = disp_q;
      end
    end else if (load) begin
      pend_d        = value;
      upd_pending_d = 1'b1;
    end else begin
      pend_d        = pend_q;
    end
  end

  // Output image for the state being entered; blank_lz is sampled once per digit.
  always_comb begin
    an_n_d        = an_n_q;
    seg_n_d       = seg_n_q;
    frame_start_d = boundary_s;
    nib_s         = disp_d[{digit_d, 2'b00} +: 4];
    if (enter_drive_s) begin
      an_n_d = ~(8'b0000_0001 << digit_d);
      if (lz_blank(disp_d, digit_d, blank_lz)) begin
        seg_n_d = 7'h7F;
      end else begin
        seg_n_d = hex_decode(nib_s);
      end
    end else if (state_d == ST_GAP) begin
      an_n_d  = 8'hFF;
      seg_n_d = 7'h7F;
    end else begin
      an_n_d  = an_n_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_DRIVE;
      digit_q       <= 3'd0;
      cnt_q         <= {CNT_W{1'b0}};
      started_q     <= 1'b0;
      disp_q        <= 32'd0;
      pend_q        <= 32'd0;
      upd_pending_q <= 1'b0;
      frame_start_q <= 1'b0;
      an_n_q        <= 8'hFF;
      seg_n_q       <= 7'h7F;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      cnt_q         <= cnt_d;
      started_q     <= started_d;
      disp_q        <= disp_d;
      pend_q        <= pend_d;
      upd_pending_q <= upd_pending_d;
      frame_start_q <= frame_start_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
    end
  end

  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;
  assign upd_pending = upd_pending_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver: a gapped (GAP_CYC=1) and a gapless (GAP_CYC=0) build
// checked every cycle against a frame-position arithmetic model.
module tb_hex_scan_driver;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] value = 32'd0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  an_n0, an_n1;
  logic [6:0]  seg_n0, seg_n1;
  logic        upd0, upd1, fs0, fs1;

  hex_scan_driver #(.DIV_CYC(DIV), .GAP_CYC(1)) dut_gap (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
    .an_n(an_n0), .seg_n(seg_n0), .upd_pending(upd0), .frame_start(fs0));

  hex_scan_driver #(.DIV_CYC(DIV), .GAP_CYC(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
    .an_n(an_n1), .seg_n(seg_n1), .upd_pending(upd1), .frame_start(fs1));

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_miss = 0;
  int          m_edge = -1;
  logic [31:0] m_disp [2];
  logic [31:0] m_pend [2];
  logic        m_upd  [2];
  logic        m_blz  [2];
  logic [6:0]  glyph  [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic int slot_len(int i);
    return (i == 0) ? DIV + 1 : DIV;
  endfunction

  function automatic logic [16:0] observed(int i);
    return (i == 0) ? {an_n0, seg_n0, upd0, fs0} : {an_n1, seg_n1, upd1, fs1};
  endfunction

  // Expected {an_n, seg_n, upd_pending, frame_start} after the latest edge.
  function automatic logic [16:0] expected(int i);
    int pos, slot, off;
    logic [31:0] rest;
    logic [7:0] an;
    logic [6:0] seg;
    if (m_edge < 0) return {8'hFF, 7'h7F, 1'b0, 1'b0};
    pos  = m_edge % (8 * slot_len(i));
    slot = pos / slot_len(i);
    off  = pos % slot_len(i);
    an   = 8'hFF;
    seg  = 7'h7F;
    if (off < DIV) begin
      an   = ~(8'd1 << slot);
      rest = m_disp[i] >> (4 * slot);
      if (!(slot > 0 && m_blz[i] && rest == 32'd0)) seg = glyph[rest[3:0]];
    end
    return {an, seg, m_upd[i], pos == 0};
  endfunction

  task automatic model_reset();
    m_edge = -1;
    for (int i = 0; i < 2; i++) begin
      m_disp[i] = 32'd0; m_pend[i] = 32'd0; m_upd[i] = 1'b0; m_blz[i] = 1'b0;
    end
  endtask

  // One clock: advance the model with the inputs the DUT sampled, return at the falling edge.
  task automatic tick();
    int pos;
    @(posedge clk);
    if (rst_n) begin
      m_edge++;
      for (int i = 0; i < 2; i++) begin
        pos = m_edge % (8 * slot_len(i));
        if (pos % slot_len(i) == 0) m_blz[i] = blank_lz;
        if (pos == 0) begin
          if (load) begin
            m_disp[i] = value; m_pend[i] = value; m_upd[i] = 1'b0;
          end else if (m_upd[i]) begin
            m_disp[i] = m_pend[i]; m_upd[i] = 1'b0;
          end
        end else if (load) begin
          m_pend[i] = value; m_upd[i] = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (observed(i) !== {8'hFF, 7'h7F, 1'b0, 1'b0}) begin
        n_miss++;
        $display("FAIL reset_state dut%0d: got %h want %h", i, observed(i), {8'hFF, 7'h7F, 2'b00});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 90; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (observed(i) !== expected(i)) begin
          n_miss++;
          $display("FAIL scan dut%0d edge %0d: got %h want %h", i, m_edge, observed(i), expected(i));
        end
      end
      n_vec++;
      if ($countones(~an_n0) > 1) begin
        n_miss++;
        $display("FAIL one_cold edge %0d: got an_n %h want at most one low bit", m_edge, an_n0);
      end
    end
  endtask

  task automatic test_load();
    logic [31:0] v;
    int at;
    for (int r = 0; r < 5; r++) begin
      v  = (r == 0) ? 32'h89AB_CDEF : $urandom;
      at = $urandom_range(2, 36);
      for (int c = 0; c < 50; c++) begin
        load  = (c == at);
        value = (c == at) ? v : $urandom;
        tick();
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (observed(i) !== expected(i)) begin
            n_miss++;
            $display("FAIL load dut%0d edge %0d: got %h want %h", i, m_edge, observed(i), expected(i));
          end
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_blank();
    logic [31:0] vals [4] = '{32'h0000_00A5, 32'h0000_0000, 32'h0003_0000, 32'h0000_0F00};
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 85; c++) begin
        load     = (c == 0);
        value    = (r < 4) ? vals[r] : ($urandom >> $urandom_range(4, 31));
        blank_lz = (r < 4) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (observed(i) !== expected(i)) begin
            n_miss++;
            $display("FAIL blank dut%0d edge %0d: got %h want %h", i, m_edge, observed(i), expected(i));
          end
        end
      end
    end
    load = 1'b0;
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    int guard;
    for (int c = 0; c < 90; c++) begin
      load  = (c == 3) || (c == 11);
      value = (c == 3) ? 32'h1111_1111 : 32'h2222_2222;
      tick();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (observed(i) !== expected(i)) begin
          n_miss++;
          $display("FAIL two_loads dut%0d edge %0d: got %h want %h", i, m_edge, observed(i), expected(i));
        end
      end
    end
    for (int r = 0; r < 3; r++) begin
      load = 1'b0;
      guard = 0;
      while (((m_edge + 1) % 40) != 0 && guard < 60) begin
        tick();
        guard++;
      end
      n_vec++;
      if (guard >= 60) begin
        n_miss++;
        $display("FAIL boundary_wait: got %0d cycles want under 60", guard);
      end
      for (int c = 0; c < 41; c++) begin
        load  = (c == 0);
        value = $urandom;
        tick();
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (observed(i) !== expected(i)) begin
            n_miss++;
            $display("FAIL boundary_load dut%0d edge %0d: got %h want %h", i, m_edge, observed(i), expected(i));
          end
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (((m_edge % 40) / 5) != 2 && guard < 60) begin
      tick();
      guard++;
    end
    load  = 1'b1;
    value = $urandom | 32'h1000_0000;
    tick();
    load  = 1'b0;
    while (!(((m_edge % 40) / 5) == 5 && (m_edge % 5) < 4) && guard < 120) begin
      tick();
      guard++;
    end
    n_vec++;
    if (guard >= 120 || upd0 !== 1'b1) begin
      n_miss++;
      $display("FAIL digit5_pending: got upd %b after %0d cycles want 1", upd0, guard);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (observed(i) !== {8'hFF, 7'h7F, 1'b0, 1'b0}) begin
        n_miss++;
        $display("FAIL async_reset dut%0d: got %h want %h", i, observed(i), {8'hFF, 7'h7F, 2'b00});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 45; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (observed(i) !== expected(i)) begin
          n_miss++;
          $display("FAIL after_reset dut%0d edge %0d: got %h want %h", i, m_edge, observed(i), expected(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_blank();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
